// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver with configurable frame format (data width, optional
//   parity, one or two stop bits) that buffers each received frame,
//   with its parity and framing error flags, in a first-word
//   fall-through FIFO.
//
// Ports
//   i_Clock       sole clock
//   i_Reset       synchronous, active-high reset
//   i_Rx_Serial   asynchronous serial line, idle high
//   i_Rx_Next     pop strobe; the head entry is removed when o_Rx_DV=1
//   i_Clear_Err   clears the sticky overrun flag
//   o_Rx_DV       FIFO non-empty; head entry valid
//   o_Rx_Byte     head entry data
//   o_Parity_Err  head entry parity mismatch
//   o_Frame_Err   head entry saw a 0 in a stop-bit sample
//   o_Overrun     sticky; a frame was dropped because the FIFO was full
//   o_Count       current FIFO occupancy
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Rx_Next,
  input  logic                 i_Clear_Err,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic [ADDR_W:0]      o_Count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int ENT_W = DATA_BITS + 2;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]        IDX_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]        IDX_ONE  = 3'(1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic              ODD_SEL  = 1'(PARITY_ODD);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   OCC_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   OCC_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Receiver state
  logic                 rx_meta, rx_s;
  state_t               state, state_nx;
  logic [CNT_W-1:0]     clk_cnt, clk_cnt_nx;
  logic [2:0]           bit_idx, bit_idx_nx;
  logic                 stop_idx, stop_idx_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 par_err, par_err_nx;
  logic                 frm_err, frm_err_nx;
  logic                 push;
  logic                 push_ferr;

  // FIFO state
  logic [ENT_W-1:0]     mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]    wr_ptr, rd_ptr;
  logic [ADDR_W:0]      count;
  logic                 overrun;
  logic                 empty, full, do_pop, do_push;
  logic [ENT_W-1:0]     head;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      state    <= S_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      rx_meta  <= i_Rx_Serial;
      rx_s     <= rx_meta;
      state    <= state_nx;
      clk_cnt  <= clk_cnt_nx;
      bit_idx  <= bit_idx_nx;
      stop_idx <= stop_idx_nx;
      shreg    <= shreg_nx;
      par_err  <= par_err_nx;
      frm_err  <= frm_err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    clk_cnt_nx  = clk_cnt;
    bit_idx_nx  = bit_idx;
    stop_idx_nx = stop_idx;
    shreg_nx    = shreg;
    par_err_nx  = par_err;
    frm_err_nx  = frm_err;
    push        = 1'b0;
    push_ferr   = frm_err;

    case (state)
      S_IDLE: begin
        clk_cnt_nx  = '0;
        bit_idx_nx  = '0;
        stop_idx_nx = 1'b0;
        if (!rx_s) state_nx = S_START;
      end

      S_START: begin
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_nx = '0;
          if (!rx_s) begin
            state_nx   = S_DATA;
            par_err_nx = 1'b0;
            frm_err_nx = 1'b0;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          clk_cnt_nx = clk_cnt + CNT_ONE;
        end
      end

      S_DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nx = '0;
          // Shift in from the top: after DATA_BITS samples the first
          // (least significant) bit has reached bit 0.
          shreg_nx = {rx_s, shreg[DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) begin
            bit_idx_nx = '0;
            state_nx   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_nx = bit_idx + IDX_ONE;
          end
        end else begin
          clk_cnt_nx = clk_cnt + CNT_ONE;
        end
      end

      S_PARITY: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nx = '0;
          par_err_nx = ((^shreg) ^ rx_s) != ODD_SEL;
          state_nx   = S_STOP;
        end else begin
          clk_cnt_nx = clk_cnt + CNT_ONE;
        end
      end

      S_STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nx = '0;
          if (!rx_s) frm_err_nx = 1'b1;
          if (stop_idx == STOP_LAST) begin
            // The final sample is folded into the pushed flag directly
            // since frm_err only updates on this same edge.
            push        = 1'b1;
            push_ferr   = frm_err | ~rx_s;
            stop_idx_nx = 1'b0;
            state_nx    = rx_s ? S_IDLE : S_WAIT_HIGH;
          end else begin
            stop_idx_nx = ~stop_idx;
          end
        end else begin
          clk_cnt_nx = clk_cnt + CNT_ONE;
        end
      end

      S_WAIT_HIGH: begin
        if (rx_s) state_nx = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase
  end

  assign empty   = (count == '0);
  assign full    = (count == OCC_FULL);
  assign do_pop  = i_Rx_Next && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + OCC_ONE;
        2'b01:   count <= count - OCC_ONE;
        default: count <= count;
      endcase
      if (push && full && !do_pop) overrun <= 1'b1;
      else if (i_Clear_Err)        overrun <= 1'b0;
    end
  end

  // When full with a simultaneous pop, wr_ptr == rd_ptr: the head is read
  // combinationally this cycle and the slot is overwritten on the edge.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset && do_push) mem[wr_ptr] <= {shreg, par_err, push_ferr};
  end

  assign head         = mem[rd_ptr];
  assign o_Rx_DV      = !empty;
  assign o_Rx_Byte    = empty ? '0 : head[ENT_W-1:2];
  assign o_Parity_Err = empty ? 1'b0 : head[1];
  assign o_Frame_Err  = empty ? 1'b0 : head[0];
  assign o_Overrun    = overrun;
  assign o_Count      = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int CPB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx_a, rx_b, nxt_a, nxt_b, clr_a, clr_b;
  logic       dv_a, dv_b, pe_a, pe_b, fe_a, fe_b, ov_a, ov_b;
  logic [7:0] byte_a, byte_b;
  logic [4:0] cnt_a;
  logic [2:0] cnt_b;

  // Instance A: 8N1, 16 entries.  Instance B: 8E2, 4 entries.
  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
    .STOP_BITS(1), .FIFO_DEPTH(16), .ADDR_W(4)
  ) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_a), .i_Rx_Next(nxt_a),
    .i_Clear_Err(clr_a), .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a),
    .o_Parity_Err(pe_a), .o_Frame_Err(fe_a), .o_Overrun(ov_a), .o_Count(cnt_a)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
    .STOP_BITS(2), .FIFO_DEPTH(4), .ADDR_W(2)
  ) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_b), .i_Rx_Next(nxt_b),
    .i_Clear_Err(clr_b), .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b),
    .o_Parity_Err(pe_b), .o_Frame_Err(fe_b), .o_Overrun(ov_b), .o_Count(cnt_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         s;
    logic [7:0] d;
    logic       pbit;
    logic       st0;
    logic       st1;
    logic [7:0] ed;
    logic       epe;
    logic       efe;
  } vec_t;

  vec_t tbl[8];

  // Reference model: per-instance queue of {data, parity_err, frame_err}
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  logic       mov_a, mov_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int s);
    return (s == 0) ? {27'd0, cnt_a} : {29'd0, cnt_b};
  endfunction

  function automatic logic [9:0] head_of(input int s);
    return (s == 0) ? {byte_a, pe_a, fe_a} : {byte_b, pe_b, fe_b};
  endfunction

  function automatic logic dv_of(input int s);
    return (s == 0) ? dv_a : dv_b;
  endfunction

  function automatic logic ov_of(input int s);
    return (s == 0) ? ov_a : ov_b;
  endfunction

  task automatic set_rx(input int s, input logic v);
    if (s == 0) rx_a = v; else rx_b = v;
  endtask

  task automatic bit_time(input int s, input logic v);
    set_rx(s, v);
    repeat (CPB) @(negedge clk);
  endtask

  // Frame format follows the instance: B adds a parity bit and a second stop.
  task automatic send(input int s, input logic [7:0] d, input logic pbit,
                      input logic st0, input logic st1);
    bit_time(s, 1'b0);
    for (int i = 0; i < 8; i++) bit_time(s, d[i]);
    if (s == 1) bit_time(s, pbit);
    bit_time(s, st0);
    if (s == 1) bit_time(s, st1);
  endtask

  task automatic idle(input int s, input int n);
    set_rx(s, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop(input int s);
    if (s == 0) nxt_a = 1'b1; else nxt_b = 1'b1;
    @(negedge clk);
    nxt_a = 1'b0;
    nxt_b = 1'b0;
  endtask

  task automatic clear_err(input int s);
    if (s == 0) clr_a = 1'b1; else clr_b = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    clr_b = 1'b0;
  endtask

  task automatic chk_head(input string tag, input int s, input logic [7:0] d,
                          input logic pe, input logic fe);
    chk({tag, "_dv"}, dv_of(s), 1'b1);
    chk({tag, "_head"}, head_of(s), {d, pe, fe});
  endtask

  // Model side of one received frame, derived from the frame contents.
  task automatic model_frame(input int s, input logic [7:0] d, input logic pbit,
                             input logic st0, input logic st1);
    logic pe, fe;
    pe = (s == 1) ? (((^d) ^ pbit) != 1'b0) : 1'b0;
    fe = (s == 1) ? !(st0 && st1) : !st0;
    if (s == 0) begin
      if (q_a.size() < 16) q_a.push_back({d, pe, fe}); else mov_a = 1'b1;
    end else begin
      if (q_b.size() < 4) q_b.push_back({d, pe, fe}); else mov_b = 1'b1;
    end
  endtask

  task automatic model_check(input string tag, input int s);
    int sz;
    logic [9:0] h;
    sz = (s == 0) ? q_a.size() : q_b.size();
    chk({tag, "_count"}, cnt_of(s), sz);
    chk({tag, "_ovr"}, ov_of(s), (s == 0) ? mov_a : mov_b);
    chk({tag, "_dv"}, dv_of(s), sz != 0);
    if (sz != 0) begin
      h = (s == 0) ? q_a[0] : q_b[0];
      chk({tag, "_head"}, head_of(s), h);
    end
  endtask

  task automatic model_pop(input int s);
    if (s == 0 && q_a.size() != 0) void'(q_a.pop_front());
    if (s == 1 && q_b.size() != 0) void'(q_b.pop_front());
    pop(s);
  endtask

  initial begin
    tbl[0] = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[1] = '{1, 8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};
    tbl[2] = '{1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
    tbl[3] = '{1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[4] = '{1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[5] = '{1, 8'hC1, 1'b0, 1'b0, 1'b0, 8'hC1, 1'b1, 1'b1};
    tbl[6] = '{0, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0};
    tbl[7] = '{0, 8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

    rst = 1'b1;
    rx_a = 1'b1; rx_b = 1'b1;
    nxt_a = 1'b0; nxt_b = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    mov_a = 1'b0; mov_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    for (int s = 0; s < 2; s++) begin
      chk("rst_dv", dv_of(s), 1'b0);
      chk("rst_count", cnt_of(s), 0);
      chk("rst_head", head_of(s), 10'd0);
      chk("rst_ovr", ov_of(s), 1'b0);
    end
    idle(0, 4);

    // Table-driven single frames
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].s, tbl[i].d, tbl[i].pbit, tbl[i].st0, tbl[i].st1);
      idle(tbl[i].s, 6);
      chk($sformatf("tbl%0d_count", i), cnt_of(tbl[i].s), 1);
      chk_head($sformatf("tbl%0d", i), tbl[i].s, tbl[i].ed, tbl[i].epe, tbl[i].efe);
      pop(tbl[i].s);
      chk($sformatf("tbl%0d_empty", i), dv_of(tbl[i].s), 1'b0);
    end

    // Back-to-back frames, no pop
    send(0, 8'h55, 1'b0, 1'b1, 1'b1);
    send(0, 8'hA3, 1'b0, 1'b1, 1'b1);
    idle(0, 4);
    chk("b2b_count2", cnt_of(0), 2);
    chk_head("b2b_first", 0, 8'h55, 1'b0, 1'b0);
    pop(0);
    chk("b2b_count1", cnt_of(0), 1);
    chk_head("b2b_second", 0, 8'hA3, 1'b0, 1'b0);
    pop(0);
    chk("b2b_empty", dv_of(0), 1'b0);
    pop(0);
    chk("pop_empty_count", cnt_of(0), 0);

    // Break: second stop low, line held low
    send(1, 8'h3C, 1'b0, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    chk("brk_count", cnt_of(1), 1);
    chk_head("brk", 1, 8'h3C, 1'b0, 1'b1);
    idle(1, 10);
    chk("brk_count_after", cnt_of(1), 1);
    send(1, 8'h11, 1'b0, 1'b1, 1'b1);
    idle(1, 4);
    chk("brk_next_count", cnt_of(1), 2);
    pop(1);
    chk_head("brk_next", 1, 8'h11, 1'b0, 1'b0);
    pop(1);

    // Glitch shorter than half a bit
    rx_a = 1'b0;
    repeat (2) @(negedge clk);
    idle(0, 20);
    chk("glitch_count", cnt_of(0), 0);
    chk("glitch_dv", dv_of(0), 1'b0);
    send(0, 8'h5A, 1'b0, 1'b1, 1'b1);
    idle(0, 4);
    chk_head("glitch_next", 0, 8'h5A, 1'b0, 1'b0);
    pop(0);

    // Overrun on the 4-deep instance
    for (int i = 1; i <= 5; i++) begin
      logic [7:0] d;
      d = 8'(i);
      send(1, d, ^d, 1'b1, 1'b1);
    end
    idle(1, 4);
    chk("ovr_count", cnt_of(1), 4);
    chk("ovr_flag", ov_of(1), 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk_head($sformatf("ovr_pop%0d", i), 1, 8'(i), 1'b0, 1'b0);
      pop(1);
    end
    chk("ovr_drained", dv_of(1), 1'b0);
    chk("ovr_sticky", ov_of(1), 1'b1);
    clear_err(1);
    chk("ovr_cleared", ov_of(1), 1'b0);

    // Randomized frames and pops against the queue model
    for (int it = 0; it < 60; it++) begin
      int s;
      logic [7:0] d;
      logic pbit, st0, st1;
      s    = $urandom_range(0, 1);
      d    = 8'($urandom);
      pbit = (^d) ^ ($urandom_range(0, 4) == 0);
      st0  = ($urandom_range(0, 7) != 0);
      st1  = ($urandom_range(0, 7) != 0);
      send(s, d, pbit, st0, st1);
      idle(s, 4);
      model_frame(s, d, pbit, st0, st1);
      model_check($sformatf("rnd%0d", it), s);
      if ($urandom_range(0, 9) < 3) begin
        model_pop(s);
        model_check($sformatf("rnd%0d_pop", it), s);
      end
    end
    for (int s = 0; s < 2; s++) begin
      while (((s == 0) ? q_a.size() : q_b.size()) != 0) begin
        model_check("drain", s);
        model_pop(s);
      end
      model_check("drain_end", s);
      clear_err(s);
      chk("drain_clr", ov_of(s), 1'b0);
    end
    mov_a = 1'b0;
    mov_b = 1'b0;

    // Reset mid-frame with two entries queued
    send(1, 8'h10, 1'b1, 1'b1, 1'b1);
    send(1, 8'h20, 1'b1, 1'b1, 1'b1);
    idle(1, 4);
    chk("mid_queued", cnt_of(1), 2);
    bit_time(1, 1'b0);
    bit_time(1, 1'b1);
    bit_time(1, 1'b0);
    bit_time(1, 1'b0);
    rst  = 1'b1;
    rx_b = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_count", cnt_of(1), 0);
    chk("mid_dv", dv_of(1), 1'b0);
    chk("mid_head", head_of(1), 10'd0);
    chk("mid_ovr", ov_of(1), 1'b0);
    idle(1, 10);
    chk("mid_no_push", cnt_of(1), 0);
    send(1, 8'h42, 1'b0, 1'b1, 1'b1);
    idle(1, 4);
    chk("mid_next_count", cnt_of(1), 1);
    chk_head("mid_next", 1, 8'h42, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, next generation of the single-byte RX.
- Configurable data width, parity and stop-bit count.
- Per-frame parity and framing error detection.
- Received frames buffered in an on-block FIFO, so the consumer pops entries instead of stalling the line.
- Sits between the board RX pin and the CPU/terminal logic, clocked from the memory clock.

Parameters:
CLKS_PER_BIT, 217, clock cycles per bit period (≥4)
DATA_BITS, 8, data bits per frame (5..8), LSB first
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, entries; power of two, ≥2
ADDR_W, 4, log2(FIFO_DEPTH)

Ports:
i_Clock  in  1  sole clock
i_Reset  in  1  synchronous, active-high reset
i_Rx_Serial  in  1  asynchronous serial line, idle high
i_Rx_Next  in  1  pop strobe; head entry removed on this edge when o_Rx_DV=1
i_Clear_Err  in  1  clears o_Overrun
o_Rx_DV  out  1  FIFO non-empty; head entry valid
o_Rx_Byte  out  DATA_BITS  head entry data
o_Parity_Err  out  1  head entry parity mismatch (0 if PARITY_EN=0)
o_Frame_Err  out  1  head entry had a 0 in a stop-bit sample
o_Overrun  out  1  sticky; a frame was dropped because the FIFO was full
o_Count  out  ADDR_W+1  current FIFO occupancy

Behaviour:
Reset:
- i_Reset sampled on the i_Clock edge.
- Sync flops set to 1; FSM goes to IDLE; counters cleared; FIFO emptied.
- All outputs 0.
- Reset mid-frame discards the partial frame; no push.

Input path:
- i_Rx_Serial passes through a 2-flop synchroniser; only the synchronised value (rx_s) is used.

FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: clock count and bit index cleared. rx_s=0 → START.
- START: count to (CLKS_PER_BIT-1)/2.
  - rx_s still 0 → DATA, count cleared.
  - else → IDLE (glitch rejected).
- DATA: sample rx_s every CLKS_PER_BIT cycles into bit[index], LSB first. After DATA_BITS samples → PARITY if PARITY_EN, else STOP.
- PARITY: sample after CLKS_PER_BIT cycles.
  - Error = (XOR of data bits XOR parity bit) != PARITY_ODD.
- STOP: sample STOP_BITS times, CLKS_PER_BIT apart.
  - Any sample = 0 sets the frame error.
  - On the final stop sample edge, push {data, parity_err, frame_err}.
  - Then → IDLE if the final sample = 1, else → WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then → IDLE. A break condition therefore yields exactly one errored entry.

FIFO:
- First-word fall-through; memory read combinationally at the read pointer.
- A push on edge N makes o_Rx_DV=1 and the head visible from cycle N+1 if the FIFO was empty.
- Pop when i_Rx_Next=1 and o_Rx_DV=1. Pop while empty is ignored; pointers are unchanged.
- Push while full with no pop in the same cycle: frame dropped, o_Overrun set, FIFO contents unchanged.
- Push and pop in the same cycle, including when full: both are performed and o_Count is unchanged.
- Pointers wrap modulo FIFO_DEPTH; o_Count is ADDR_W+1 bits wide so it can represent FIFO_DEPTH.
- o_Overrun:
  - Set has priority over i_Clear_Err in the same cycle.
  - Cleared only by i_Clear_Err or reset.

Test Plan:
Bench settings for all scenarios: CLKS_PER_BIT=8, defaults otherwise unless stated.
1. Send 0x55 then 0xA3 back-to-back with no pop → o_Count=2, head 0x55 with both error flags 0. Pulse i_Rx_Next → head 0xA3, o_Count=1. Second pop → o_Rx_DV=0.
2. PARITY_EN=1, PARITY_ODD=0. Send 0x07 with parity bit 1 → entry 0x07, o_Parity_Err=0. Send 0x07 with parity bit 0 → o_Parity_Err=1.
3. STOP_BITS=2. Send 0x3C with second stop bit 0 → entry 0x3C, o_Frame_Err=1. Hold line low 40 cycles → no further entries. Line high, then send 0x11 → clean entry.
4. Glitch: line low for 2 cycles only → FSM returns to IDLE, no push, o_Count=0.
5. FIFO_DEPTH=4. Send 5 frames 0x01..0x05 with no pop → o_Count=4, o_Overrun=1, head 0x01, 0x05 lost. Pop 4 times → 0x01..0x04 in order. Pulse i_Clear_Err → o_Overrun=0.
6. Assert i_Reset during the DATA bits of 0x99 with 2 entries queued → next cycle o_Count=0, all outputs 0. Following frame 0x42 is received correctly.
